// File: rtl/branch_ctrl_fsm.sv
// branch_ctrl_fsm
//   Initiator side of the branch-resolution handshake. A start pulse in IDLE
//   with a branch opcode runs COMPARE -> EVAL -> RESOLVE. The ALU is held in
//   compare mode, UC_control is raised toward the branch-condition gate, and
//   the PC write toward ALUOut follows branch_taken. Saturating counters
//   record taken and not-taken outcomes.
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   start, opcode       : request and opcode from the main control FSM
//   branch_taken        : gate result, used only in RESOLVE
//   alu_srcA/B, alu_op  : registered ALU drive (compare = A, B, SUB)
//   UC_control, UC_op   : registered gate enable and condition select
//   pc_write, pc_source : PC write enable (combinational) and source select
//   busy, done          : combinational status decoded from state
//   bad_op              : registered pulse for a non-branch start
//   taken_cnt, not_taken_cnt : saturating statistics counters
module branch_ctrl_fsm #(
  parameter int unsigned CNT_W  = 16,
  parameter logic [5:0]  OP_BEQ = 6'h04,
  parameter logic [5:0]  OP_BNE = 6'h05,
  parameter logic [5:0]  OP_BLE = 6'h06,
  parameter logic [5:0]  OP_BGT = 6'h07
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             branch_taken,
  output logic             alu_srcA,
  output logic [1:0]       alu_srcB,
  output logic [2:0]       alu_op,
  output logic             UC_control,
  output logic [1:0]       UC_op,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             busy,
  output logic             done,
  output logic             bad_op,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_EVAL,
    S_RESOLVE
  } state_t;

  localparam logic [2:0]       ALU_SUB = 3'b011;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             alu_srcA_q, alu_srcA_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             uc_control_q, uc_control_d;
  logic [1:0]       uc_op_q, uc_op_d;
  logic [1:0]       pc_source_q, pc_source_d;
  logic             bad_op_q, bad_op_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;

  logic             is_branch;
  logic [1:0]       op_code_sel;

  always_comb begin
    is_branch   = 1'b1;
    op_code_sel = 2'b00;
    unique case (opcode)
      OP_BEQ:  op_code_sel = 2'b00;
      OP_BNE:  op_code_sel = 2'b01;
      OP_BLE:  op_code_sel = 2'b10;
      OP_BGT:  op_code_sel = 2'b11;
      default: is_branch   = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    uc_op_d         = uc_op_q;
    bad_op_d        = 1'b0;
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_branch) begin
            uc_op_d = op_code_sel;
            state_d = S_COMPARE;
          end else begin
            bad_op_d = 1'b1;
          end
        end
      end
      S_COMPARE: state_d = S_EVAL;
      S_EVAL:    state_d = S_RESOLVE;
      S_RESOLVE: begin
        state_d = S_IDLE;
        if (branch_taken) begin
          if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_ONE;
        end else begin
          if (not_taken_cnt_q != '1) not_taken_cnt_d = not_taken_cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up
    // with the state they belong to, rather than lagging it by a cycle.
    alu_srcA_d   = (state_d != S_IDLE);
    alu_op_d     = (state_d != S_IDLE) ? ALU_SUB : 3'b000;
    uc_control_d = (state_d == S_EVAL) || (state_d == S_RESOLVE);
    pc_source_d  = (state_d == S_RESOLVE) ? 2'b01 : 2'b00;

    // Decoded outputs are masked by reset so a reset arriving in RESOLVE
    // cannot produce a PC write or completion in that same cycle.
    busy     = (state_q != S_IDLE) && !reset;
    done     = (state_q == S_RESOLVE) && !reset;
    pc_write = (state_q == S_RESOLVE) && branch_taken && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      alu_srcA_q      <= 1'b0;
      alu_op_q        <= '0;
      uc_control_q    <= 1'b0;
      uc_op_q         <= '0;
      pc_source_q     <= '0;
      bad_op_q        <= 1'b0;
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      alu_srcA_q      <= alu_srcA_d;
      alu_op_q        <= alu_op_d;
      uc_control_q    <= uc_control_d;
      uc_op_q         <= uc_op_d;
      pc_source_q     <= pc_source_d;
      bad_op_q        <= bad_op_d;
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign alu_srcA      = alu_srcA_q;
  assign alu_srcB      = 2'b00;
  assign alu_op        = alu_op_q;
  assign UC_control    = uc_control_q;
  assign UC_op         = uc_op_q;
  assign pc_source     = pc_source_q;
  assign bad_op        = bad_op_q;
  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl_fsm.sv
// Testbench for branch_ctrl_fsm: a 16-bit-counter instance and a 2-bit-counter
// instance share stimulus; expectations come from a cycle-offset model of a
// branch accepted at cycle A occupying cycles A+1..A+3.
module tb_branch_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic        branch_taken;

  logic        alu_srcA, UC_control, pc_write, busy, done, bad_op;
  logic [1:0]  alu_srcB, UC_op, pc_source;
  logic [2:0]  alu_op;
  logic [15:0] taken_cnt, not_taken_cnt;

  logic        alu_srcA2, UC_control2, pc_write2, busy2, done2, bad_op2;
  logic [1:0]  alu_srcB2, UC_op2, pc_source2;
  logic [2:0]  alu_op2;
  logic [1:0]  taken_cnt2, not_taken_cnt2;

  branch_ctrl_fsm u_dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_op(alu_op), .UC_control(UC_control), .UC_op(UC_op),
    .pc_write(pc_write), .pc_source(pc_source), .busy(busy), .done(done),
    .bad_op(bad_op), .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
  );

  branch_ctrl_fsm #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .alu_srcA(alu_srcA2), .alu_srcB(alu_srcB2),
    .alu_op(alu_op2), .UC_control(UC_control2), .UC_op(UC_op2),
    .pc_write(pc_write2), .pc_source(pc_source2), .busy(busy2), .done(done2),
    .bad_op(bad_op2), .taken_cnt(taken_cnt2), .not_taken_cnt(not_taken_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         acc      = -10;   // cycle in which the current branch was accepted
  int         t16 = 0, n16 = 0, t2 = 0, n2 = 0;
  logic [1:0] uop      = 2'b00;
  bit         badp     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic step(input bit s, input bit [5:0] op, input bit bt, input bit r);
    int off;
    bit inb, isbr, e_res;
    start = s; opcode = op; branch_taken = bt; reset = r;
    off   = cyc - acc;
    inb   = (off >= 1) && (off <= 3);
    isbr  = (op >= 6'd4) && (op <= 6'd7);
    e_res = inb && (off == 3);
    @(negedge clk);
    chk("busy",       busy,       32'(inb && !r));
    chk("done",       done,       32'(e_res && !r));
    chk("pc_write",   pc_write,   32'(e_res && bt && !r));
    chk("alu_srcA",   alu_srcA,   32'(inb));
    chk("alu_srcB",   alu_srcB,   32'd0);
    chk("alu_op",     alu_op,     inb ? 32'd3 : 32'd0);
    chk("UC_control", UC_control, 32'(inb && off >= 2));
    chk("pc_source",  pc_source,  e_res ? 32'd1 : 32'd0);
    chk("UC_op",      UC_op,      32'(uop));
    chk("bad_op",     bad_op,     32'(badp));
    chk("taken_cnt",      taken_cnt,      32'(t16));
    chk("not_taken_cnt",  not_taken_cnt,  32'(n16));
    chk("taken_cnt_w2",     taken_cnt2,     32'(t2));
    chk("not_taken_cnt_w2", not_taken_cnt2, 32'(n2));
    chk("done_w2",    done2,      32'(e_res && !r));
    @(posedge clk);
    if (r) begin
      acc = -10; uop = 2'b00; badp = 1'b0;
      t16 = 0; n16 = 0; t2 = 0; n2 = 0;
    end else begin
      badp = !inb && s && !isbr;
      if (e_res) begin
        if (bt) begin
          t16 = (t16 == 65535) ? t16 : t16 + 1;
          t2  = (t2 == 3) ? t2 : t2 + 1;
        end else begin
          n16 = (n16 == 65535) ? n16 : n16 + 1;
          n2  = (n2 == 3) ? n2 : n2 + 1;
        end
      end
      if (!inb && s && isbr) begin
        acc = cyc;
        uop = 2'(op - 6'd4);
      end
    end
    cyc++;
    #1;
  endtask

  // Full branch; branch_taken is driven inverted outside RESOLVE to show it is ignored.
  task automatic branch(input bit [5:0] op, input bit bt);
    step(1'b1, op, !bt, 1'b0);
    step(1'b0, op, !bt, 1'b0);
    step(1'b0, op, !bt, 1'b0);
    step(1'b0, op, bt, 1'b0);
  endtask

  initial begin
    bit [5:0] rop;
    reset = 1'b1; start = 1'b0; opcode = '0; branch_taken = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    step(0, 6'h00, 0, 0);
    branch(6'h04, 1'b1);          // BEQ taken
    step(0, 6'h00, 0, 0);
    branch(6'h07, 1'b0);          // BGT not taken
    step(0, 6'h00, 0, 0);

    // Back-to-back BNE then BLE, with an ignored start during the first
    step(1, 6'h05, 0, 0);
    step(0, 6'h05, 0, 0);
    step(1, 6'h06, 1, 0);
    step(0, 6'h05, 1, 0);
    step(1, 6'h06, 1, 0);
    step(0, 6'h06, 1, 0);
    step(0, 6'h06, 1, 0);
    step(0, 6'h06, 0, 0);
    step(0, 6'h00, 0, 0);

    // Non-branch opcode
    step(1, 6'h23, 1, 0);
    step(0, 6'h00, 1, 0);
    step(0, 6'h00, 0, 0);

    // Reset while in EVAL
    step(1, 6'h04, 1, 0);
    step(0, 6'h04, 1, 0);
    step(0, 6'h04, 1, 1);
    step(0, 6'h04, 1, 0);
    step(0, 6'h00, 1, 0);

    // Five taken: the 2-bit counters saturate at 3
    repeat (5) branch(6'h04, 1'b1);
    step(0, 6'h00, 0, 0);
    repeat (4) branch(6'h06, 1'b0);
    step(0, 6'h00, 0, 0);

    // Random traffic with occasional resets
    repeat (600) begin
      if ($urandom_range(0, 1) == 0) rop = 6'(4 + $urandom_range(0, 3));
      else                           rop = 6'($urandom_range(0, 63));
      step(bit'($urandom_range(0, 2) != 0), rop, bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 39) == 0));
    end
    step(0, 6'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
